// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// Funct3 opcodes, FSM state encoding and operand signedness helpers.
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    function automatic logic is_signed_a(input logic [2:0] funct3);
        return (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
               (funct3 == F3_DIV)  || (funct3 == F3_REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] funct3);
        return (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_special_case.sv
// Detects divide corner cases (divide by zero, signed overflow) that bypass
// the iterative datapath, and supplies their architecturally fixed result.
module muldiv_special_case
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic [2:0]      funct3,
    output logic            hit,
    output logic [XLEN-1:0] result
);

    logic div_zero;
    logic overflow;

    assign div_zero = (operand_b == '0);
    assign overflow = is_signed_a(funct3) &&
                      (operand_a == {1'b1, {(XLEN-1){1'b0}}}) &&
                      (operand_b == '1);

    // NOTE: every output gets a default before the branches so no latch is inferred.
    always_comb begin
        hit    = 1'b0;
        result = '0;
        if (funct3[2]) begin
            if (div_zero) begin
                hit    = 1'b1;
                result = funct3[1] ? operand_a : '1;
            end else if (overflow) begin
                hit    = 1'b1;
                result = funct3[1] ? '0 : operand_a;
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit: one shared shift/add-subtract
// datapath, start/busy/done handshake, kill abort and a divide fast path.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            Start_i,
    input  logic            Kill_i,
    input  logic [XLEN-1:0] OperandA_i,
    input  logic [XLEN-1:0] OperandB_i,
    input  logic [2:0]      Funct3_i,
    output logic            Busy_o,
    output logic            Done_o,
    output logic [XLEN-1:0] Result_o
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    state_t            state;
    logic [2:0]        op_q;
    logic              neg_a_q, neg_b_q;
    logic [XLEN-1:0]   a_q, b_q;
    logic [2*XLEN-1:0] acc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              special_q;
    logic [XLEN-1:0]   special_res_q;
    logic              done_q;
    logic [XLEN-1:0]   result_q;

    logic              sign_a, sign_b;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              spc_hit;
    logic [XLEN-1:0]   spc_result;

    assign sign_a = is_signed_a(Funct3_i) & OperandA_i[XLEN-1];
    assign sign_b = is_signed_b(Funct3_i) & OperandB_i[XLEN-1];
    assign mag_a  = sign_a ? -OperandA_i : OperandA_i;
    assign mag_b  = sign_b ? -OperandB_i : OperandB_i;

    muldiv_special_case #(.XLEN(XLEN)) u_special (
        .operand_a (OperandA_i),
        .operand_b (OperandB_i),
        .funct3    (Funct3_i),
        .hit       (spc_hit),
        .result    (spc_result)
    );

    // Single adder: multiply adds the multiplicand, divide subtracts the divisor.
    logic [XLEN:0]     add_lhs, add_rhs, add_sum;
    logic              add_cin;
    logic [2*XLEN-1:0] acc_next;

    always_comb begin
        if (op_q[2]) begin
            add_lhs = acc_q[2*XLEN-1:XLEN-1];
            add_rhs = ~{1'b0, b_q};
            add_cin = 1'b1;
        end else begin
            add_lhs = {1'b0, acc_q[2*XLEN-1:XLEN]};
            add_rhs = acc_q[0] ? {1'b0, a_q} : '0;
            add_cin = 1'b0;
        end
        add_sum = add_lhs + add_rhs + {{XLEN{1'b0}}, add_cin};

        if (!op_q[2])
            acc_next = {add_sum, acc_q[XLEN-1:1]};
        else if (!add_sum[XLEN])
            acc_next = {add_sum[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        else
            acc_next = {acc_q[2*XLEN-2:0], 1'b0};
    end

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot, rem, fin_result;

    always_comb begin
        prod = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
        quot = (neg_a_q ^ neg_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem  = neg_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        if (special_q)
            fin_result = special_res_q;
        else begin
            case (op_q)
                F3_MUL:                   fin_result = prod[XLEN-1:0];
                F3_MULH, F3_MULHSU,
                F3_MULHU:                 fin_result = prod[2*XLEN-1:XLEN];
                F3_DIV, F3_DIVU:          fin_result = quot;
                default:                  fin_result = rem;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= ST_IDLE;
            op_q          <= '0;
            neg_a_q       <= 1'b0;
            neg_b_q       <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            acc_q         <= '0;
            cnt_q         <= '0;
            special_q     <= 1'b0;
            special_res_q <= '0;
            done_q        <= 1'b0;
            result_q      <= '0;
        end else begin
            done_q <= 1'b0;
            if (Kill_i) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: if (Start_i) begin
                        op_q          <= Funct3_i;
                        neg_a_q       <= sign_a;
                        neg_b_q       <= sign_b;
                        a_q           <= mag_a;
                        b_q           <= mag_b;
                        acc_q         <= {{XLEN{1'b0}}, Funct3_i[2] ? mag_a : mag_b};
                        cnt_q         <= CNT_W'(XLEN);
                        special_q     <= spc_hit;
                        special_res_q <= spc_result;
                        state         <= spc_hit ? ST_FIN : ST_CALC;
                    end
                    ST_CALC: begin
                        acc_q <= acc_next;
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1))
                            state <= ST_FIN;
                    end
                    ST_FIN: begin
                        result_q <= fin_result;
                        done_q   <= 1'b1;
                        state    <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign Busy_o   = (state != ST_IDLE);
    assign Done_o   = done_q;
    assign Result_o = result_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit, parametrised in operand width; sits beside the combinational integer ALU in the execute stage.
- Executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, selected by Funct3, over multiple cycles using one shared shift/add-subtract datapath.
- The pipeline stalls on Busy_o and captures Result_o when Done_o pulses.
- Adds a start/busy/done handshake, an abort input, and a single-cycle fast path for divide corner cases.

Parameters:
- XLEN, 32, operand/result width; any value ≥ 8.
- CNT_W, $clog2(XLEN)+1, iteration counter width; derived, not overridden.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous active-high reset.
- Start_i  input  1  request; sampled only in IDLE.
- Kill_i  input  1  synchronous abort (pipeline flush).
- OperandA_i  input  XLEN  rs1 value (multiplicand/dividend).
- OperandB_i  input  XLEN  rs2 value (multiplier/divisor).
- Funct3_i  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Busy_o  output  1  high in CALC and FIN.
- Done_o  output  1  one-cycle pulse; Result_o valid in that cycle.
- Result_o  output  XLEN  registered result; held until the next completion.

Behaviour:
- Reset (async, any state): state=IDLE; Busy_o=0, Done_o=0, Result_o=0; internal registers cleared.
- States:
  - IDLE: Start_i=1 and Kill_i=0 at an edge latches OperandA_i, OperandB_i, Funct3_i and operand signs, converts operands to magnitudes for signed ops, and loads the counter with XLEN. Next state is FIN if a special case is detected, otherwise CALC.
  - CALC: one radix-2 iteration per cycle.
    - Multiply: shift-add into a 2·XLEN accumulator.
    - Divide: restoring shift-subtract giving quotient and remainder.
    - Counter decrements; after the counter reaches 0 (XLEN CALC cycles), go to FIN.
  - FIN: one cycle. Apply sign correction and select the result. Result_o is written at the FIN→IDLE edge; Done_o=1 in the following IDLE cycle.
- Latency, with Start_i sampled at edge E:
  - Normal op: Done_o high during the cycle after edge E+XLEN+1 (XLEN+2 cycles).
  - Special case: Done_o high during the cycle after edge E+1.
- Done_o is high only in an IDLE cycle, so Start_i in the Done_o cycle is accepted (back-to-back issue).
- Start_i while Busy_o=1 is ignored; there is no queueing.
- Kill_i=1 in any state: return to IDLE at the next edge with no Done_o, and Result_o unchanged. Kill_i together with Start_i in IDLE: Kill_i wins and the op is not started.
- Sign rules:
  - MULH: both operands signed.
  - MULHSU: A signed, B unsigned.
  - MULHU/DIVU/REMU: unsigned.
  - Quotient is negative iff the signs differ; the remainder takes the dividend's sign.
- Result select: MUL takes the low XLEN bits of the product; MULH/MULHSU/MULHU take the high XLEN bits.
- Special cases (FIN directly):
  - Divisor=0: DIV/DIVU give all ones; REM/REMU give OperandA.
  - Signed overflow (A = most-negative, B = −1): DIV gives A; REM gives 0.
- Operand changes after acceptance have no effect.
- Busy_o is combinational from the state.
- Done_o and Result_o are registered.

Decomposition:
- Shared package muldiv_pkg:
  - Funct3 opcode localparams (MUL…REMU).
  - State encoding IDLE/CALC/FIN (2-bit).
  - Helper function is_signed_a/is_signed_b(funct3).
- One sub-module: muldiv_special_case (combinational).
  - Inputs: operands, funct3.
  - Outputs: hit flag and fixed result.
- The FSM and iterative datapath stay in muldiv_unit.

Test Plan:
- MUL 7×6, then MULHU 0xFFFFFFFF×0xFFFFFFFF → Result_o 0x0000002A; then 0xFFFFFFFE. Done_o is a single pulse exactly 34 cycles after Start_i; Busy_o is high for 33 cycles.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHSU 0xFFFFFFFF×0x00000002 → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIV x/0 → 0xFFFFFFFF and REM 5/0 → 5; DIV 0x80000000/−1 → 0x80000000 and REM → 0. Each gives Done_o 2 cycles after Start_i.
- Kill_i pulsed in the 10th CALC cycle → no Done_o, Result_o keeps its previous value, and Busy_o=0 next cycle. Start_i held during Busy_o → ignored. Start_i in the Done_o cycle → second op accepted.
- rst_i asserted asynchronously mid-CALC → Busy_o, Done_o and Result_o are 0 immediately. After release, an idle Start_i with DIVU 9/3 returns 3.
